// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multi-cycle controller and the rest of the RV32I core.
// The master side is the controller. The slave side is the decode stage, ALU,
// memories and register file.
//
// Handshake: imem_req/dmem_req rise and then stay high until the cycle where
// the matching ready is 1. That cycle completes the access. A ready that is
// seen while its req is low has no effect.
interface multicycle_ctrl_if;
   // decode stage / datapath -> controller
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic        branch_taken;
   // memories -> controller
   logic        imem_ready;
   logic        dmem_ready;
   // controller -> memories / datapath
   logic        imem_req;
   logic        ir_we;
   logic        dmem_req;
   logic        dmem_we;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic [31:0] instret;
   logic        halted;
   logic        trap;
   // current FSM state, for observation only
   logic [2:0]  dbg_state;

   modport master (
      input  opcode, rd, funct3, branch_taken, imem_ready, dmem_ready,
      output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, instret, halted, trap, dbg_state
   );

   modport slave (
      output opcode, rd, funct3, branch_taken, imem_ready, dmem_ready,
      input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, instret, halted, trap, dbg_state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. It runs FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and produces the datapath strobes and selects. It also counts retired
// instructions and holds sticky halt/trap flags.
// Strobes are combinational from the registered state and the current inputs.
// They are forced low while rst is high.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] instret_q, instret_d;
   logic        halted_q, halted_d;
   logic        trap_q, trap_d;
   logic        retire;

   logic is_load, is_store, is_jal, is_jalr, is_branch, is_wb_class, is_system_ok;

   logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
   logic [1:0] wb_sel, pc_sel;

   // Opcode classification. The opcode stays stable from EXEC until retire.
   always_comb begin
      is_load      = (bus.opcode == OPC_LOAD);
      is_store     = (bus.opcode == OPC_STORE);
      is_jal       = (bus.opcode == OPC_JAL);
      is_jalr      = (bus.opcode == OPC_JALR);
      is_branch    = (bus.opcode == OPC_BRANCH);
      is_wb_class  = (bus.opcode == OPC_OP)    || (bus.opcode == OPC_OPIMM) ||
                     (bus.opcode == OPC_LUI)   || (bus.opcode == OPC_AUIPC) ||
                     is_jal || is_jalr;
      is_system_ok = (bus.opcode == OPC_SYSTEM) && (bus.funct3 == 3'b000);
   end

   // Next state, wait counter and retire decision.
   // The wait counter is only nonzero while FETCH or MEM is stalled, so it
   // is always zero when one of those states is entered.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = 8'd0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.imem_ready) begin
               state_d = S_DECODE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d == TIMEOUT_CNT) state_d = S_TRAP;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_wb_class) begin
               state_d = S_WB;
            end else if (is_branch) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_system_ok) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_MEM: begin
            if (bus.dmem_ready) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d == TIMEOUT_CNT) state_d = S_TRAP;
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   // Retire counter and sticky status flags.
   always_comb begin
      instret_d = instret_q + {31'd0, retire};
      halted_d  = halted_q | (state_d == S_HALT);
      trap_d    = trap_q   | (state_d == S_TRAP);
   end

   // All controller state. A synchronous reset returns to FETCH and clears the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= 8'd0;
         instret_q  <= 32'd0;
         halted_q   <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         instret_q  <= instret_d;
         halted_q   <= halted_d;
         trap_q     <= trap_d;
      end
   end

   // Datapath strobes and selects. They are decoded from state and held low during rst.
   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_we    = bus.imem_ready;
            end
            S_EXEC: begin
               if (is_branch) begin
                  pc_we  = 1'b1;
                  pc_sel = bus.branch_taken ? 2'd1 : 2'd0;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               pc_we    = is_store && bus.dmem_ready;
            end
            S_WB: begin
               rf_we  = (bus.rd != 5'd0);
               pc_we  = 1'b1;
               wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
               pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req  = imem_req;
   assign bus.ir_we     = ir_we;
   assign bus.dmem_req  = dmem_req;
   assign bus.dmem_we   = dmem_we;
   assign bus.rf_we     = rf_we;
   assign bus.wb_sel    = wb_sel;
   assign bus.pc_we     = pc_we;
   assign bus.pc_sel    = pc_sel;
   assign bus.instret   = instret_q;
   assign bus.halted    = halted_q;
   assign bus.trap      = trap_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each cycle's expected strobe vector is pushed to
// a queue as the inputs for that cycle are driven. It is popped and compared
// on the falling edge. Retire count and sticky flags are checked after each
// instruction.
module tb_multicycle_ctrl;

   localparam int TO = 4;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // clock / reset
   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();
   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;
   logic [9:0]  exp_q[$];
   logic [31:0] exp_instret = 32'd0;
   logic        exp_halted  = 1'b0;
   logic        exp_trap    = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel}
   function automatic logic [9:0] sv(input logic ireq, input logic irw, input logic dreq,
                                     input logic dwe, input logic rfw, input logic [1:0] wbs,
                                     input logic pcw, input logic [1:0] pcs);
      return {ireq, irw, dreq, dwe, rfw, wbs, pcw, pcs};
   endfunction

   function automatic logic [9:0] observed();
      return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we,
              bus.wb_sel, bus.pc_we, bus.pc_sel};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // One cycle: drive inputs, queue expectation, compare mid-cycle, advance.
   task automatic step(input logic [9:0] e, input logic irdy, input logic drdy, input string tag);
      exp_q.push_back(e);
      bus.imem_ready = irdy;
      bus.dmem_ready = drdy;
      @(negedge clk);
      check_val(tag, {22'd0, observed()}, {22'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check_val({tag, "_instret"}, bus.instret, exp_instret);
      check_val({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, exp_halted});
      check_val({tag, "_trap"}, {31'd0, bus.trap}, {31'd0, exp_trap});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(10'd0, 1'b1, 1'b1, "rst_strobes");
      step(10'd0, 1'b1, 1'b1, "rst_strobes");
      rst = 1'b0;
      exp_instret = 32'd0;
      exp_halted  = 1'b0;
      exp_trap    = 1'b0;
      check_status("reset");
   endtask

   // One instruction. iwait/dwait are the ready-low cycles before ready=1.
   task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                            input logic taken, input int iwait, input int dwait);
      logic st;
      logic [1:0] wbs, pcs;
      st = (op == STORE);
      bus.opcode = op;
      bus.rd = rd;
      bus.funct3 = f3;
      bus.branch_taken = taken;
      for (int i = 0; i < iwait; i++) step(sv(1, 0, 0, 0, 0, 2'd0, 0, 2'd0), 1'b0, rnd(), "fetch_wait");
      step(sv(1, 1, 0, 0, 0, 2'd0, 0, 2'd0), 1'b1, rnd(), "fetch");
      step(10'd0, rnd(), rnd(), "decode");
      if (op == LOAD || op == STORE) begin
         step(10'd0, rnd(), rnd(), "exec_mem");
         for (int i = 0; i < dwait; i++) step(sv(0, 0, 1, st, 0, 2'd0, 0, 2'd0), rnd(), 1'b0, "mem_wait");
         step(sv(0, 0, 1, st, 0, 2'd0, st, 2'd0), rnd(), 1'b1, "mem_done");
         if (!st) step(sv(0, 0, 0, 0, rd != 5'd0, 2'd1, 1, 2'd0), rnd(), rnd(), "wb_load");
         exp_instret++;
      end else if (op == OP || op == OPIMM || op == LUI || op == AUIPC || op == JAL || op == JALR) begin
         wbs = (op == JAL || op == JALR) ? 2'd2 : 2'd0;
         pcs = (op == JAL) ? 2'd1 : ((op == JALR) ? 2'd2 : 2'd0);
         step(10'd0, rnd(), rnd(), "exec_alu");
         step(sv(0, 0, 0, 0, rd != 5'd0, wbs, 1, pcs), rnd(), rnd(), "wb");
         exp_instret++;
      end else if (op == BRANCH) begin
         step(sv(0, 0, 0, 0, 0, 2'd0, 1, {1'b0, taken}), rnd(), rnd(), "exec_branch");
         exp_instret++;
      end else if (op == SYSTEM && f3 == 3'b000) begin
         step(10'd0, rnd(), rnd(), "exec_system");
         exp_instret++;
         exp_halted = 1'b1;
      end else begin
         step(10'd0, rnd(), rnd(), "exec_illegal");
         exp_trap = 1'b1;
      end
      check_status("instr");
   endtask

   logic [6:0] legal_ops [10];

   initial begin
      legal_ops = '{LOAD, STORE, OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, BRANCH};
      bus.opcode = OPIMM;
      bus.rd = 5'd0;
      bus.funct3 = 3'd0;
      bus.branch_taken = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // directed instructions
      run_instr(OPIMM, 5'd1, 3'd0, 1'b0, 0, 0);   // ADDI x1
      run_instr(LOAD, 5'd5, 3'd2, 1'b0, 0, 3);    // LW, 3 wait cycles
      run_instr(BRANCH, 5'd0, 3'd0, 1'b1, 0, 0);  // BEQ taken
      run_instr(BRANCH, 5'd0, 3'd0, 1'b0, 0, 0);  // BEQ not taken
      run_instr(JALR, 5'd0, 3'd0, 1'b0, 0, 0);    // JALR x0
      run_instr(JAL, 5'd1, 3'd0, 1'b0, 1, 0);
      run_instr(STORE, 5'd3, 3'd2, 1'b0, 2, 1);
      run_instr(LOAD, 5'd0, 3'd2, 1'b0, 3, 0);    // load to x0, fetch at timeout edge

      // random legal traffic, waits below the timeout
      for (int n = 0; n < 16; n++) begin
         run_instr(legal_ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)),
                   3'($urandom_range(0, 7)), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // ECALL halts and holds
      run_instr(SYSTEM, 5'd0, 3'd0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) step(10'd0, rnd(), rnd(), "halt_hold");
      check_status("halt_hold");
      do_reset();

      // illegal opcode traps and holds
      run_instr(7'b0000000, 5'd1, 3'd0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) step(10'd0, rnd(), rnd(), "trap_hold");
      check_status("trap_hold");
      do_reset();

      // SYSTEM with nonzero funct3 is illegal
      run_instr(SYSTEM, 5'd0, 3'd1, 1'b0, 0, 0);
      do_reset();

      // fetch timeout: imem_ready stuck low
      bus.opcode = OPIMM;
      for (int i = 0; i < TO; i++) step(sv(1, 0, 0, 0, 0, 2'd0, 0, 2'd0), 1'b0, rnd(), "fetch_to_wait");
      exp_trap = 1'b1;
      check_status("fetch_timeout");
      step(10'd0, 1'b1, rnd(), "fetch_to_dropped");
      do_reset();

      // data memory timeout on a load
      bus.opcode = LOAD;
      step(sv(1, 1, 0, 0, 0, 2'd0, 0, 2'd0), 1'b1, 1'b0, "fetch");
      step(10'd0, 1'b0, 1'b0, "decode");
      step(10'd0, 1'b0, 1'b0, "exec_mem");
      for (int i = 0; i < TO; i++) step(sv(0, 0, 1, 0, 0, 2'd0, 0, 2'd0), rnd(), 1'b0, "mem_to_wait");
      exp_trap = 1'b1;
      check_status("mem_timeout");
      step(10'd0, rnd(), 1'b1, "mem_to_dropped");
      do_reset();

      // reset in MEM during a stalled store
      run_instr(OPIMM, 5'd2, 3'd0, 1'b0, 0, 0);
      bus.opcode = STORE;
      step(sv(1, 1, 0, 0, 0, 2'd0, 0, 2'd0), 1'b1, 1'b0, "fetch");
      step(10'd0, 1'b0, 1'b0, "decode");
      step(10'd0, 1'b0, 1'b0, "exec_mem");
      step(sv(0, 0, 1, 1, 0, 2'd0, 0, 2'd0), 1'b0, 1'b0, "mem_wait");
      rst = 1'b1;
      step(10'd0, 1'b0, 1'b1, "rst_in_mem");
      rst = 1'b0;
      exp_instret = 32'd0;
      check_status("after_rst");
      step(sv(1, 0, 0, 0, 0, 2'd0, 0, 2'd0), 1'b0, 1'b1, "fetch_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
